// File: rtl/combo_entry_ctrl_if.sv
// combo_entry_ctrl_if: request/result channel between system logic and the lock driver
//   req_valid/req_ready  request handshake (accept = req_valid & req_ready)
//   req_op               00 open, 01 close, 10 change code, 11 reserved
//   req_code/req_newcode current code / new code (change only)
//   done/status          one-cycle result strobe, status 00 OK, 01 REJECTED, 10 ALARM, 11 ERROR
interface combo_entry_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_code;
    logic [3:0] req_newcode;
    logic       done;
    logic [1:0] status;
    modport master (output req_valid, req_op, req_code, req_newcode, input req_ready, done, status);
    modport slave (input req_valid, req_op, req_code, req_newcode, output req_ready, done, status);
endinterface

// File: rtl/combo_entry_ctrl.sv
// combo_entry_ctrl: drives a combination lock's code lines and buttons for one request, returns one result
//   Clock, Resetn  clock (rising edge), asynchronous active-low reset
//   req            request/result channel (slave side)
//   lock_state     lock state: 00 IN, 01 OPEN, 10 NEW, 11 ALARM
//   code_out       to lock x3..x0, held between requests
//   confirm_out    to lock confirm button
//   change_out     to lock change button
module combo_entry_ctrl #(
    parameter int SETTLE    = 4,
    parameter int PULSE_LEN = 3,
    parameter int RESP_WAIT = 16
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    combo_entry_ctrl_if.slave        req,
    input  logic [1:0]               lock_state,
    output logic [3:0]               code_out,
    output logic                     confirm_out,
    output logic                     change_out
);
    localparam int MX = (SETTLE > PULSE_LEN) ? ((SETTLE > RESP_WAIT) ? SETTLE : RESP_WAIT)
                                             : ((PULSE_LEN > RESP_WAIT) ? PULSE_LEN : RESP_WAIT);
    localparam int CW = $clog2(MX) + 1;
    localparam logic [CW-1:0] SET_T = CW'(SETTLE - 1);
    localparam logic [CW-1:0] PUL_T = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] RSP_T = CW'(RESP_WAIT - 1);
    localparam logic [1:0] L_IN = 2'b00, L_OPEN = 2'b01, L_NEW = 2'b10, L_ALARM = 2'b11;
    localparam logic [1:0] S_OK = 2'b00, S_REJ = 2'b01, S_ALM = 2'b10, S_ERR = 2'b11;
    localparam logic [1:0] OP_OPEN = 2'b00, OP_CLOSE = 2'b01, OP_CHANGE = 2'b10, OP_RSV = 2'b11;

    typedef enum logic [3:0] {IDLE, CHECK, SETUP, PRESS, WAIT, SETUP2, PRESS2, WAIT2, REPORT} state_t;

    state_t        st;
    logic [CW-1:0] cnt;
    logic [1:0]    op;
    logic [3:0]    code, newcode;
    logic          rdy, done_r;
    logic [1:0]    status_r;

    logic       chk_ok, to_setup2;
    logic [1:0] chk_status, stay_val, target, hit_status, exp_status;

    // Start-state rule: alarm dominates, then reserved op, then open/change need IN, close needs OPEN.
    assign chk_ok     = lock_state != L_ALARM && op != OP_RSV && lock_state == (op == OP_CLOSE ? L_OPEN : L_IN);
    assign chk_status = lock_state == L_ALARM ? S_ALM : S_ERR;
    // While waiting, stay_val is "lock has not reacted yet"; any other value resolves the wait.
    assign stay_val   = st == WAIT2 ? L_NEW : op == OP_CLOSE ? L_OPEN : L_IN;
    assign target     = st == WAIT2 ? L_IN : op == OP_OPEN ? L_OPEN : op == OP_CLOSE ? L_IN : L_NEW;
    assign to_setup2  = st == WAIT && op == OP_CHANGE && lock_state == L_NEW;
    assign hit_status = lock_state == target ? S_OK
                      : (lock_state == L_ALARM && st == WAIT && op != OP_CLOSE) ? S_ALM : S_ERR;
    assign exp_status = (st == WAIT2 || op == OP_CLOSE) ? S_ERR : S_REJ;

    assign req.req_ready = rdy;
    assign req.done      = done_r;
    assign req.status    = status_r;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            st          <= IDLE;
            cnt         <= '0;
            op          <= '0;
            code        <= '0;
            newcode     <= '0;
            rdy         <= 1'b1;
            done_r      <= 1'b0;
            status_r    <= S_OK;
            code_out    <= '0;
            confirm_out <= 1'b0;
            change_out  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (st)
                IDLE: if (req.req_valid) begin
                    st      <= CHECK;
                    rdy     <= 1'b0;
                    op      <= req.req_op;
                    code    <= req.req_code;
                    newcode <= req.req_newcode;
                end
                CHECK: if (chk_ok) begin
                    st  <= SETUP;
                    cnt <= '0;
                    if (op != OP_CLOSE) code_out <= code;
                end else begin
                    st       <= REPORT;
                    done_r   <= 1'b1;
                    status_r <= chk_status;
                end
                SETUP, SETUP2: if (cnt == SET_T) begin
                    st          <= st == SETUP ? PRESS : PRESS2;
                    cnt         <= '0;
                    confirm_out <= st == SETUP2 || op != OP_CHANGE;
                    change_out  <= st == SETUP && op == OP_CHANGE;
                end else cnt <= cnt + 1'b1;
                PRESS, PRESS2: if (cnt == PUL_T) begin
                    st          <= st == PRESS ? WAIT : WAIT2;
                    cnt         <= '0;
                    confirm_out <= 1'b0;
                    change_out  <= 1'b0;
                end else cnt <= cnt + 1'b1;
                WAIT, WAIT2: if (to_setup2) begin
                    st       <= SETUP2;
                    cnt      <= '0;
                    code_out <= newcode;
                end else if (lock_state != stay_val || cnt == RSP_T) begin
                    st       <= REPORT;
                    done_r   <= 1'b1;
                    status_r <= lock_state != stay_val ? hit_status : exp_status;
                end else cnt <= cnt + 1'b1;
                REPORT: begin
                    st  <= IDLE;
                    rdy <= 1'b1;
                end
                default: begin
                    st  <= IDLE;
                    rdy <= 1'b1;
                end
            endcase
        end
    end
endmodule
